// File: rtl/tohost_pkg.sv
// Shared types and constants for the tohost completion monitor.
package tohost_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } tohost_state_e;

    localparam logic [31:0] TOHOST_PASS_CODE    = 32'd1;
    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;
    localparam logic [3:0]  TOHOST_FULL_MASK    = 4'b1111;

    // Only a full-word store to the tohost address carries a verdict.
    function automatic logic tohost_hit(input logic        we,
                                        input logic [31:0] addr,
                                        input logic [3:0]  mask,
                                        input logic [31:0] tohost_addr);
        return we && (addr == tohost_addr) && (mask == TOHOST_FULL_MASK);
    endfunction

endpackage

// File: rtl/tohost_monitor_sat_counter.sv
// Saturating up-counter: counts while en is high and holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next count: increment unless disabled or already saturated.
    always_comb begin
        q_d = q_q;
        if (en && (q_q != {W{1'b1}})) begin
            q_d = q_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            q_d = q_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= {W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tohost_monitor.sv
// Snoops core stores to tohost and latches a PASS/FAIL/TIMEOUT verdict.
// The watchdog exists only when TOHOST_MONITOR_WATCHDOG_EN is defined.
module tohost_monitor
    import tohost_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 5000,
    parameter int          CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_we,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wmask,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [30:0]      test_num,
    output logic [CNT_W-1:0] cycle_count
);

    tohost_state_e    state_q, state_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             timeout_q, timeout_d;
    logic [30:0]      test_num_q, test_num_d;
    logic             hit_s;
    logic             expiry_s;
    logic             cnt_en_s;
    logic [CNT_W-1:0] cycle_count_s;

    assign hit_s = tohost_hit(mem_we, mem_addr, mem_wmask, TOHOST_ADDR);

`ifdef TOHOST_MONITOR_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    assign expiry_s = (cycle_count_s == WD_LIMIT);
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES != 0);
    assign expiry_s         = 1'b0;
`endif

    // Verdict decode: a decodable write beats a simultaneous watchdog expiry.
    always_comb begin
        state_d    = state_q;
        test_num_d = test_num_q;
        if (state_q == ST_RUN) begin
            if (hit_s && (mem_wdata == TOHOST_PASS_CODE)) begin
                state_d = ST_PASS;
            end else if (hit_s && mem_wdata[0]) begin
                state_d    = ST_FAIL;
                test_num_d = mem_wdata[31:1];
            end else if (expiry_s) begin
                state_d = ST_TIMEOUT;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            state_d = state_q;
        end
        done_d    = (state_d != ST_RUN);
        pass_d    = (state_d == ST_PASS);
        fail_d    = (state_d == ST_FAIL);
        timeout_d = (state_d == ST_TIMEOUT);
    end

    // The count freezes on the timeout edge so it reads TIMEOUT_CYCLES-1.
    assign cnt_en_s = (state_q == ST_RUN) && (state_d != ST_TIMEOUT);

    // FSM state and registered output decodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
            test_num_q <= 31'd0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            timeout_q  <= timeout_d;
            test_num_q <= test_num_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en_s),
        .q   (cycle_count_s)
    );

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign test_num    = test_num_q;
    assign cycle_count = cycle_count_s;

endmodule
